// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master req/grant arbiter with tenure preemption and bus mux; define BUS_ARB_RR_EN for round-robin ties
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_address,
  input  logic [31:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [7:0]  m1_address,
  input  logic [31:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        bus_wr,
  output logic [7:0]  bus_address,
  output logic [31:0] bus_dout
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  state_t     r_state;
  state_t     w_next;
  state_t     w_other;
  logic [7:0] r_hold_cnt;
  logic       w_own_req;
  logic       w_oth_req;
  logic       w_preempt;
  logic       w_tie_m1;
`ifdef BUS_ARB_RR_EN
  logic       r_last_owner;
  assign w_tie_m1 = ~r_last_owner;
`else
  assign w_tie_m1 = 1'b0;
`endif
  // next owner: IDLE picks a requester, an owner hands off on release or when its contested tenure is used up
  always_comb begin
    w_own_req = (r_state == GRANT1) ? m1_req : m0_req;
    w_oth_req = (r_state == GRANT1) ? m0_req : m1_req;
    w_other   = (r_state == GRANT0) ? GRANT1 : GRANT0;
    w_preempt = (MAX_HOLD != 0) && w_oth_req && (r_hold_cnt == HOLD_LIM);
    w_next    = (r_state == IDLE) ? ((m0_req && m1_req) ? (w_tie_m1 ? GRANT1 : GRANT0) :
                                     m0_req ? GRANT0 : m1_req ? GRANT1 : IDLE) :
                (!w_own_req || w_preempt) ? (w_oth_req ? w_other : IDLE) : r_state;
  end
  // state register and contested-tenure counter, cleared on any handoff or when uncontested
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_hold_cnt <= (w_next != r_state || !w_oth_req) ? 8'd0 :
                    (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;
    end
  end
`ifdef BUS_ARB_RR_EN
  // remember who was granted most recently so the other master wins the next IDLE tie
  always_ff @(posedge clk) begin
    if (!reset_n) r_last_owner <= 1'b1;
    else if (w_next != r_state && w_next != IDLE) r_last_owner <= (w_next == GRANT1);
  end
`endif
  assign m0_grant = (r_state == GRANT0);
  assign m1_grant = (r_state == GRANT1);
  // drive the bus from the granted master, zeros when idle
  always_comb begin
    bus_wr      = m0_grant ? m0_wr      : m1_grant ? m1_wr      : 1'b0;
    bus_address = m0_grant ? m0_address : m1_grant ? m1_address : 8'h00;
    bus_dout    = m0_grant ? m0_dout    : m1_grant ? m1_dout    : 32'h0;
  end
  a_grant_onehot: assert property (@(posedge clk) !(m0_grant && m1_grant));
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench with a per-cycle owner model for MAX_HOLD=4 and MAX_HOLD=0 instances
module tb_bus_arbiter;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;
  logic        g0 [2];
  logic        g1 [2];
  logic        bwr [2];
  logic [7:0]  badr [2];
  logic [31:0] bdat [2];
  int errors = 0;
  int checks = 0;
  int own [2];
  int streak [2];
  int recent [2];
  bit valid = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(g0[0]), .m1_grant(g1[0]), .bus_wr(bwr[0]), .bus_address(badr[0]), .bus_dout(bdat[0])
  );
  bus_arbiter #(.MAX_HOLD(0)) u_nopre (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(g0[1]), .m1_grant(g1[1]), .bus_wr(bwr[1]), .bus_address(badr[1]), .bus_dout(bdat[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rst_idle();
    reset_n = 1'b0;
    m0_req  = 1'b0;
    m1_req  = 1'b0;
    cyc(1);
    reset_n = 1'b1;
  endtask

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // owner model: 0 = nobody, 1 = m0, 2 = m1; streak counts contested cycles of the current tenure
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int nxt, mine, theirs, other_id;
      if (!reset_n) begin
        own[k]    = 0;
        streak[k] = 0;
        recent[k] = 2;
        valid     = 1'b1;
      end else begin
        if (own[k] == 0) begin
          theirs = 0;
          nxt = (m0_req && m1_req) ? (RR ? 3 - recent[k] : 1) : m0_req ? 1 : m1_req ? 2 : 0;
        end else begin
          other_id = 3 - own[k];
          mine     = (own[k] == 1) ? int'(m0_req) : int'(m1_req);
          theirs   = (own[k] == 1) ? int'(m1_req) : int'(m0_req);
          if (mine == 0 || (hold_of(k) > 0 && theirs != 0 && streak[k] + 1 >= hold_of(k)))
            nxt = (theirs != 0) ? other_id : 0;
          else
            nxt = own[k];
        end
        streak[k] = (nxt != own[k] || theirs == 0) ? 0 : streak[k] + 1;
        if (nxt != 0 && nxt != own[k]) recent[k] = nxt;
        own[k] = nxt;
      end
    end
  end

  // compare every cycle, away from the rising edge
  always @(negedge clk) begin
    if (valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d m0_grant", k), 32'(g0[k]), 32'(own[k] == 1));
        chk($sformatf("dut%0d m1_grant", k), 32'(g1[k]), 32'(own[k] == 2));
        chk($sformatf("dut%0d bus_wr", k), 32'(bwr[k]),
            32'((own[k] == 1) ? m0_wr : (own[k] == 2) ? m1_wr : 1'b0));
        chk($sformatf("dut%0d bus_address", k), 32'(badr[k]),
            32'((own[k] == 1) ? m0_address : (own[k] == 2) ? m1_address : 8'h00));
        chk($sformatf("dut%0d bus_dout", k), bdat[k],
            (own[k] == 1) ? m0_dout : (own[k] == 2) ? m1_dout : 32'h0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b1; m0_address = 8'h5A; m0_dout = 32'h0123_4567;
    m1_req = 1'b1; m1_wr = 1'b0; m1_address = 8'hC3; m1_dout = 32'h89AB_CDEF;
    cyc(2);
    chk("reset m0_grant", 32'(g0[0]), 32'd0);
    chk("reset m1_grant", 32'(g1[0]), 32'd0);
    chk("reset bus_wr", 32'(bwr[0]), 32'd0);
    chk("reset bus_address", 32'(badr[0]), 32'h00);
    chk("reset bus_dout", bdat[0], 32'h0);
    reset_n = 1'b1;
    cyc(1);
    chk("post-reset m0_grant", 32'(g0[0]), 32'd1);
    chk("post-reset bus_address", 32'(badr[0]), 32'h5A);

    rst_idle();
    m1_req = 1'b1; m1_wr = 1'b1; m1_address = 8'h24; m1_dout = 32'hDEAD_BEEF;
    cyc(1);
    chk("single m1_grant", 32'(g1[0]), 32'd1);
    chk("single bus_wr", 32'(bwr[0]), 32'd1);
    chk("single bus_address", 32'(badr[0]), 32'h24);
    chk("single bus_dout", bdat[0], 32'hDEAD_BEEF);
    m1_req = 1'b0;
    cyc(1);
    chk("release m1_grant", 32'(g1[0]), 32'd0);
    chk("release bus_address", 32'(badr[0]), 32'h00);
    chk("release bus_dout", bdat[0], 32'h0);

    rst_idle();
    m0_req = 1'b1; m1_req = 1'b1;
    cyc(1);
    chk("tie m0_grant", 32'(g0[0]), 32'd1);
    cyc(2);
    chk("tie hold m0_grant", 32'(g0[0]), 32'd1);
    m0_req = 1'b0;
    cyc(1);
    chk("handoff m1_grant", 32'(g1[0]), 32'd1);
    chk("handoff m0_grant", 32'(g0[0]), 32'd0);
    chk("handoff nopre m1_grant", 32'(g1[1]), 32'd1);

    rst_idle();
    m0_req = 1'b1; m0_wr = 1'b0; m0_address = 8'h81; m0_dout = 32'hA5A5_0F0F;
    cyc(3);
    chk("uncontested m0_grant", 32'(g0[0]), 32'd1);
    m1_req = 1'b1;
    cyc(3);
    chk("contested 3 m0_grant", 32'(g0[0]), 32'd1);
    cyc(1);
    chk("preempt m1_grant", 32'(g1[0]), 32'd1);
    chk("preempt m0_grant", 32'(g0[0]), 32'd0);
    chk("nopre keeps m0_grant", 32'(g0[1]), 32'd1);
    cyc(3);
    chk("m1 tenure m1_grant", 32'(g1[0]), 32'd1);
    cyc(1);
    chk("preempt back m0_grant", 32'(g0[0]), 32'd1);
    cyc(300);
    chk("nopre long m0_grant", 32'(g0[1]), 32'd1);

    rst_idle();
    m1_req = 1'b1;
    cyc(1);
    chk("mid m1_grant", 32'(g1[0]), 32'd1);
    reset_n = 1'b0; m0_req = 1'b1;
    cyc(1);
    chk("mid reset m1_grant", 32'(g1[0]), 32'd0);
    chk("mid reset m0_grant", 32'(g0[0]), 32'd0);
    chk("mid reset bus_dout", bdat[0], 32'h0);
    reset_n = 1'b1; m1_req = 1'b0;
    cyc(1);
    chk("after mid reset m0_grant", 32'(g0[0]), 32'd1);

    rst_idle();
    m0_req = 1'b1;
    cyc(1);
    m0_req = 1'b0;
    cyc(1);
    m0_req = 1'b1; m1_req = 1'b1;
    cyc(1);
    chk("tie2 m1_grant", 32'(g1[0]), 32'(RR));
    chk("tie2 m0_grant", 32'(g0[0]), 32'(!RR));
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(1);
    m0_req = 1'b1; m1_req = 1'b1;
    cyc(1);
    chk("tie3 m0_grant", 32'(g0[0]), 32'd1);

    for (int i = 0; i < 80; i++) begin
      m0_req = 1'($urandom_range(0, 3) != 0);
      m1_req = 1'($urandom_range(0, 3) != 0);
      m0_wr = 1'($urandom); m1_wr = 1'($urandom);
      m0_address = 8'($urandom); m1_address = 8'($urandom);
      m0_dout = $urandom; m1_dout = $urandom;
      cyc(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
